mvu_pump_splitter: RTL and testbench

Fast-clock gearbox that halves the element count of an AXI-stream word so a double-pumped compute core sees each slow-rate input word as two consecutive fast-rate beats. It sits directly upstream of the pumped DSP compute core and runs entirely in the `clk2x` domain. It splits each `ELEMS`-element input word into a low-half beat and a high-half beat, zero-pads odd element counts, and forwards a `last` flag on the high-half beat only. A two-entry buffer lets the block accept a new word while the current one drains, so back-to-back output needs no bubbles.

---
 rtl/mvu_pump_splitter.sv | 128 ++++++++++++
 tb/tb_mvu_pump_splitter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_pump_splitter.sv
// Fast-clock gearbox: splits each ELEMS-element stream word into a low-half and
// a high-half beat for a double-pumped core, with a one-word skid buffer.
module mvu_pump_splitter #(
  parameter int ELEMS      = 2,
  parameter int ELEM_WIDTH = 8
) (
  input  logic                                     clk2x,
  input  logic                                     rst,
  input  logic [ELEMS*ELEM_WIDTH-1:0]              s_tdata,
  input  logic                                     s_tlast,
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  output logic [((ELEMS+1)/2)*ELEM_WIDTH-1:0]      m_tdata,
  output logic                                     m_tsel,
  output logic                                     m_tlast,
  output logic                                     m_tvalid,
  input  logic                                     m_tready
);

  localparam int HALF = (ELEMS + 1) / 2;
  localparam int WW   = ELEMS * ELEM_WIDTH;
  localparam int HW   = HALF * ELEM_WIDTH;

  // Element j of the selected half; indices past the word end read as zero.
  function automatic logic [HW-1:0] pick_half(input logic [WW-1:0] word, input logic sel);
    logic [HW-1:0] beat;
    int            idx;
    beat = {HW{1'b0}};
    for (int j = 0; j < HALF; j++) begin
      idx = sel ? (HALF + j) : j;
      if (idx < ELEMS) begin
        beat[j*ELEM_WIDTH +: ELEM_WIDTH] = word[idx*ELEM_WIDTH +: ELEM_WIDTH];
      end else begin
        beat[j*ELEM_WIDTH +: ELEM_WIDTH] = {ELEM_WIDTH{1'b0}};
      end
    end
    return beat;
  endfunction

  logic [WW-1:0] h_data_r, h_data_nxt_s;
  logic          h_last_r, h_last_nxt_s;
  logic          h_vld_r,  h_vld_nxt_s;
  logic [WW-1:0] s_data_r, s_data_nxt_s;
  logic          s_last_r, s_last_nxt_s;
  logic          s_vld_r,  s_vld_nxt_s;
  logic          ph_r,     ph_nxt_s;
  logic          in_xfer_s;
  logic          out_xfer_s;
  logic          h_release_s;

  assign in_xfer_s   = s_tvalid && s_tready && !rst;
  assign out_xfer_s  = h_vld_r && m_tready;
  assign h_release_s = out_xfer_s && ph_r;

  // Next-state of main entry, skid entry and phase.
  always_comb begin
    h_data_nxt_s = h_data_r;
    h_last_nxt_s = h_last_r;
    h_vld_nxt_s  = h_vld_r;
    s_data_nxt_s = s_data_r;
    s_last_nxt_s = s_last_r;
    s_vld_nxt_s  = s_vld_r;
    if (out_xfer_s) begin
      ph_nxt_s = ~ph_r;
    end else begin
      ph_nxt_s = ph_r;
    end
    if (h_release_s) begin
      if (s_vld_r) begin
        h_data_nxt_s = s_data_r;
        h_last_nxt_s = s_last_r;
        h_vld_nxt_s  = 1'b1;
        s_vld_nxt_s  = 1'b0;
      end else if (in_xfer_s) begin
        h_data_nxt_s = s_tdata;
        h_last_nxt_s = s_tlast;
        h_vld_nxt_s  = 1'b1;
      end else begin
        h_vld_nxt_s  = 1'b0;
      end
    end else if (in_xfer_s) begin
      // Ready is low whenever S is full, so an accepted word always has a home.
      if (!h_vld_r) begin
        h_data_nxt_s = s_tdata;
        h_last_nxt_s = s_tlast;
        h_vld_nxt_s  = 1'b1;
        ph_nxt_s     = 1'b0;
      end else begin
        s_data_nxt_s = s_tdata;
        s_last_nxt_s = s_tlast;
        s_vld_nxt_s  = 1'b1;
      end
    end else begin
      h_vld_nxt_s = h_vld_r;
    end
  end

  // Control state and registered control outputs.
  always_ff @(posedge clk2x) begin
    if (rst) begin
      h_vld_r  <= 1'b0;
      s_vld_r  <= 1'b0;
      ph_r     <= 1'b0;
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
      m_tsel   <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      h_vld_r  <= h_vld_nxt_s;
      s_vld_r  <= s_vld_nxt_s;
      ph_r     <= ph_nxt_s;
      s_tready <= !s_vld_nxt_s;
      m_tvalid <= h_vld_nxt_s;
      m_tsel   <= ph_nxt_s;
      m_tlast  <= ph_nxt_s && h_last_nxt_s;
    end
  end

  // Payload storage and the registered output beat; contents need no reset.
  always_ff @(posedge clk2x) begin
    h_data_r <= h_data_nxt_s;
    h_last_r <= h_last_nxt_s;
    s_data_r <= s_data_nxt_s;
    s_last_r <= s_last_nxt_s;
    m_tdata  <= pick_half(h_data_nxt_s, ph_nxt_s);
  end

endmodule

// File: tb/tb_mvu_pump_splitter.sv
// Bench for mvu_pump_splitter: an ELEMS=4 instance for directed tests and an
// ELEMS=3 instance for the odd-count and randomized scoreboard tests.
module tb_mvu_pump_splitter;

  logic        clk2x = 1'b0;
  logic        rst   = 1'b1;

  logic [31:0] e_s_tdata;
  logic        e_s_tlast, e_s_tvalid, e_s_tready;
  logic [15:0] e_m_tdata;
  logic        e_m_tsel, e_m_tlast, e_m_tvalid, e_m_tready;

  logic [23:0] o_s_tdata;
  logic        o_s_tlast, o_s_tvalid, o_s_tready;
  logic [15:0] o_m_tdata;
  logic        o_m_tsel, o_m_tlast, o_m_tvalid, o_m_tready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk2x = ~clk2x;

  mvu_pump_splitter #(.ELEMS(4), .ELEM_WIDTH(8)) dut_even (
    .clk2x(clk2x), .rst(rst),
    .s_tdata(e_s_tdata), .s_tlast(e_s_tlast), .s_tvalid(e_s_tvalid), .s_tready(e_s_tready),
    .m_tdata(e_m_tdata), .m_tsel(e_m_tsel), .m_tlast(e_m_tlast), .m_tvalid(e_m_tvalid),
    .m_tready(e_m_tready)
  );

  mvu_pump_splitter #(.ELEMS(3), .ELEM_WIDTH(8)) dut_odd (
    .clk2x(clk2x), .rst(rst),
    .s_tdata(o_s_tdata), .s_tlast(o_s_tlast), .s_tvalid(o_s_tvalid), .s_tready(o_s_tready),
    .m_tdata(o_m_tdata), .m_tsel(o_m_tsel), .m_tlast(o_m_tlast), .m_tvalid(o_m_tvalid),
    .m_tready(o_m_tready)
  );

  task automatic step();
    @(posedge clk2x);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    e_s_tdata = 32'h0; e_s_tlast = 1'b0; e_s_tvalid = 1'b1; e_m_tready = 1'b0;
    o_s_tdata = 24'h0; o_s_tlast = 1'b0; o_s_tvalid = 1'b1; o_m_tready = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({e_m_tvalid, e_m_tsel, e_m_tlast} !== 3'b000) begin
      n_err++; $display("FAIL reset_even_ctrl: got %b expected 000", {e_m_tvalid, e_m_tsel, e_m_tlast});
    end
    n_cmp++;
    if ({o_m_tvalid, o_m_tsel, o_m_tlast} !== 3'b000) begin
      n_err++; $display("FAIL reset_odd_ctrl: got %b expected 000", {o_m_tvalid, o_m_tsel, o_m_tlast});
    end
    e_s_tvalid = 1'b0; o_s_tvalid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++;
    if ({e_s_tready, o_s_tready, e_m_tvalid, o_m_tvalid} !== 4'b1100) begin
      n_err++; $display("FAIL reset_release: got ready/valid %b expected 1100",
                        {e_s_tready, o_s_tready, e_m_tvalid, o_m_tvalid});
    end
  endtask

  task automatic test_odd();
    o_m_tready = 1'b1;
    o_s_tdata = 24'h030201; o_s_tlast = 1'b1; o_s_tvalid = 1'b1;
    n_cmp++;
    if (o_s_tready !== 1'b1) begin
      n_err++; $display("FAIL odd_ready: got %b expected 1", o_s_tready);
    end
    step();
    o_s_tvalid = 1'b0;
    n_cmp++;
    if ({o_m_tvalid, o_m_tsel, o_m_tlast, o_m_tdata} !== {1'b1, 1'b0, 1'b0, 16'h0201}) begin
      n_err++; $display("FAIL odd_low: got v%b s%b l%b %h expected v1 s0 l0 0201",
                        o_m_tvalid, o_m_tsel, o_m_tlast, o_m_tdata);
    end
    step();
    n_cmp++;
    if ({o_m_tvalid, o_m_tsel, o_m_tlast, o_m_tdata} !== {1'b1, 1'b1, 1'b1, 16'h0003}) begin
      n_err++; $display("FAIL odd_high: got v%b s%b l%b %h expected v1 s1 l1 0003",
                        o_m_tvalid, o_m_tsel, o_m_tlast, o_m_tdata);
    end
    step();
    n_cmp++;
    if (o_m_tvalid !== 1'b0) begin
      n_err++; $display("FAIL odd_drain: got valid %b expected 0", o_m_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    logic [15:0] exp_beat [6];
    logic        exp_sel, exp_last;
    w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    exp_beat = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B};
    e_m_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if ((c % 2 == 0) && (c < 6)) begin
        e_s_tvalid = 1'b1; e_s_tdata = w[c/2]; e_s_tlast = (c == 4);
      end else begin
        e_s_tvalid = 1'b0;
      end
      n_cmp++;
      if (e_s_tready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready cycle %0d: got %b expected 1", c, e_s_tready);
      end
      step();
      if (c < 6) begin
        exp_sel = (c % 2 == 1);
        exp_last = (c == 5);
        n_cmp++;
        if ({e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata} !== {1'b1, exp_sel, exp_last, exp_beat[c]}) begin
          n_err++; $display("FAIL b2b_beat %0d: got v%b s%b l%b %h expected v1 s%b l%b %h", c,
                            e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata, exp_sel, exp_last, exp_beat[c]);
        end
      end else begin
        n_cmp++;
        if (e_m_tvalid !== 1'b0) begin
          n_err++; $display("FAIL b2b_idle cycle %0d: got valid %b expected 0", c, e_m_tvalid);
        end
      end
    end
    e_s_tvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [17:0] got [$];
    logic [15:0] exp_data;
    logic        acc;
    int          idx;
    w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    idx = 0;
    e_m_tready = 1'b0;
    e_s_tvalid = 1'b1; e_s_tdata = w[0]; e_s_tlast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      acc = e_s_tvalid && e_s_tready;
      step();
      if (acc) idx++;
      if (idx < 3) e_s_tdata = w[idx];
      n_cmp++;
      if ({e_m_tvalid, e_m_tsel, e_m_tdata} !== {1'b1, 1'b0, 16'h0201}) begin
        n_err++; $display("FAIL bp_hold cycle %0d: got v%b s%b %h expected v1 s0 0201",
                          c, e_m_tvalid, e_m_tsel, e_m_tdata);
      end
    end
    n_cmp++;
    if (idx != 2 || e_s_tready !== 1'b0) begin
      n_err++; $display("FAIL bp_fill: got accepted %0d ready %b expected 2 and 0", idx, e_s_tready);
    end
    e_m_tready = 1'b1;
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      acc = e_s_tvalid && e_s_tready;
      if (e_m_tvalid && e_m_tready) got.push_back({e_m_tlast, e_m_tsel, e_m_tdata});
      step();
      if (acc) idx++;
      if (idx < 3) e_s_tdata = w[idx];
      else e_s_tvalid = 1'b0;
    end
    e_s_tvalid = 1'b0;
    n_cmp++;
    if (got.size() != 6 || idx != 3) begin
      n_err++; $display("FAIL bp_drain: got %0d beats %0d words expected 6 beats 3 words", got.size(), idx);
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp_data = 16'((w[i/2] >> ((i % 2) * 16)) & 32'h0000FFFF);
        n_cmp++;
        if (got[i] !== {1'b0, (i % 2 == 1), exp_data}) begin
          n_err++; $display("FAIL bp_order beat %0d: got %h expected %h", i, got[i],
                            {1'b0, (i % 2 == 1), exp_data});
        end
      end
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    e_m_tready = 1'b1;
    e_s_tdata = 32'hDDCCBBAA; e_s_tlast = 1'b1; e_s_tvalid = 1'b1;
    step();
    e_s_tvalid = 1'b0;
    n_cmp++;
    if ({e_m_tvalid, e_m_tsel, e_m_tdata} !== {1'b1, 1'b0, 16'hBBAA}) begin
      n_err++; $display("FAIL rstmid_low: got v%b s%b %h expected v1 s0 bbaa", e_m_tvalid, e_m_tsel, e_m_tdata);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (e_m_tvalid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_flush: got valid %b expected 0", e_m_tvalid);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (e_m_tvalid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_no_high cycle %0d: got valid %b expected 0", c, e_m_tvalid);
      end
    end
    e_s_tdata = 32'h44332211; e_s_tlast = 1'b0; e_s_tvalid = 1'b1;
    n_cmp++;
    if (e_s_tready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_ready: got %b expected 1", e_s_tready);
    end
    step();
    e_s_tvalid = 1'b0;
    n_cmp++;
    if ({e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata} !== {1'b1, 1'b0, 1'b0, 16'h2211}) begin
      n_err++; $display("FAIL rstmid_restart_low: got v%b s%b l%b %h expected v1 s0 l0 2211",
                        e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata);
    end
    step();
    n_cmp++;
    if ({e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata} !== {1'b1, 1'b1, 1'b0, 16'h4433}) begin
      n_err++; $display("FAIL rstmid_restart_high: got v%b s%b l%b %h expected v1 s1 l0 4433",
                        e_m_tvalid, e_m_tsel, e_m_tlast, e_m_tdata);
    end
    repeat (2) step();
  endtask

  // Randomized valid/ready on the ELEMS=3 instance against a beat-queue model.
  task automatic test_random();
    logic [17:0] exp_q [$];
    logic [17:0] exp_b, obs_b;
    logic [15:0] lo, hi;
    logic        acc;
    int          sent, cycles;
    sent = 0;
    cycles = 0;
    o_s_tvalid = 1'b0;
    o_m_tready = 1'b0;
    while ((sent < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      acc = o_s_tvalid && o_s_tready;
      if (acc) begin
        lo = 16'(o_s_tdata % 24'h010000);
        hi = 16'(o_s_tdata / 24'h010000);
        exp_q.push_back({1'b0, 1'b0, lo});
        exp_q.push_back({o_s_tlast, 1'b1, hi});
        sent++;
      end
      if (o_m_tvalid && o_m_tready) begin
        obs_b = {o_m_tlast, o_m_tsel, o_m_tdata};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra_beat: got %h expected none", obs_b);
        end else begin
          exp_b = exp_q.pop_front();
          if (obs_b !== exp_b) begin
            n_err++; $display("FAIL rand_beat: got last/sel/data %h expected %h", obs_b, exp_b);
          end
        end
      end
      step();
      cycles++;
      if (acc || !o_s_tvalid) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          o_s_tvalid = 1'b1;
          o_s_tdata = 24'($urandom);
          o_s_tlast = ($urandom_range(0, 2) == 0);
        end else begin
          o_s_tvalid = 1'b0;
        end
      end
      o_m_tready = ($urandom_range(0, 3) != 0);
    end
    o_s_tvalid = 1'b0;
    n_cmp++;
    if (sent != 1000 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_complete: got sent %0d pending %0d expected 1000 and 0", sent, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_odd();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
